mmp_iddmm_finalsub: RTL and testbench

- Final conditional-subtraction stage of the 4096-bit IDDMM multiplier. Sits directly downstream of the IDDMM PE control FSM.
- Accepts `comp_req` and the latched top carry `ref_an`. Reads the 32×128-bit accumulator A and modulus M word by word.
- Writes the reduced result R to the result buffer: R = A − M when `ref_an`=1 or A ≥ M, else R = A. Pulses `comp_end` when done.

---
 rtl/mmp_iddmm_finalsub.sv | 155 +++++++++++++++
 tb/tb_mmp_iddmm_finalsub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_iddmm_finalsub.sv
// mmp_iddmm_finalsub: IDDMM final conditional subtraction, R = (an | A>=M) ? A-M : A.
// Option MMP_FINALSUB_FAST_AN_EN: when an=1 the compare pass is skipped.
module mmp_iddmm_finalsub #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int AW     = 5,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          comp_req,
   input  logic          ref_an,
   output logic          comp_end,
   output logic          busy,
   output logic          rd_ena,
   output logic [AW-1:0] rd_addr,
   input  logic [K-1:0]  a_rdata,
   input  logic [K-1:0]  m_rdata,
   output logic          res_wr_ena,
   output logic [AW-1:0] res_wr_addr,
   output logic [K-1:0]  res_wr_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMP     = 3'd1;
   localparam logic [2:0] S_CMP_DRN = 3'd2;
   localparam logic [2:0] S_SUB     = 3'd3;
   localparam logic [2:0] S_SUB_DRN = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   logic [2:0]        state;
   logic              armed;
   logic              an;
   logic              b;
   logic              sel;
   logic [AW-1:0]     wa;
   logic [RD_LAT-1:0] vld;
   logic              dv;
   logic              b_nxt;
   logic              wr_v;
   logic [K:0]        diff;

   // Word subtract at K+1 bits; the top bit is the borrow A_k < M_k + b.
   always_comb begin
      dv          = vld[RD_LAT-1];
      diff        = {1'b0, a_rdata} - {1'b0, m_rdata} - {{K{1'b0}}, b};
      b_nxt       = diff[K];
      wr_v        = dv && (state == S_SUB || state == S_SUB_DRN);
      res_wr_ena  = wr_v;
      res_wr_addr = '0;
      res_wr_data = '0;
      if (wr_v) begin
         res_wr_addr = wa;
         res_wr_data = sel ? diff[K-1:0] : a_rdata;
      end
   end

   // Read-data valid tracker, RD_LAT cycles behind rd_ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld <= '0;
      else        vld <= (vld << 1) | RD_LAT'(rd_ena);
   end

   // Re-arm only after comp_req has been seen low once after a finish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b1;
      else        armed <= !comp_req || (armed && state != S_DONE);
   end

   // Control: compare pass, subtract/write pass, done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         an       <= 1'b0;
         b        <= 1'b0;
         sel      <= 1'b0;
         wa       <= '0;
         comp_end <= 1'b0;
         busy     <= 1'b0;
         rd_ena   <= 1'b0;
         rd_addr  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (comp_req && armed) begin
                  an      <= ref_an;
                  b       <= 1'b0;
                  wa      <= '0;
                  busy    <= 1'b1;
                  rd_ena  <= 1'b1;
                  rd_addr <= '0;
                  sel     <= 1'b0;
`ifdef MMP_FINALSUB_FAST_AN_EN
                  if (ref_an) begin
                     sel   <= 1'b1;
                     state <= S_SUB;
                  end else begin
                     state <= S_CMP;
                  end
`else
                  state   <= S_CMP;
`endif
               end
            end
            S_CMP, S_SUB: begin
               if (dv) begin
                  b  <= b_nxt;
                  wa <= wa + 1'b1;
               end
               if (rd_addr == LAST) begin
                  rd_ena  <= 1'b0;
                  rd_addr <= '0;
                  state   <= (state == S_CMP) ? S_CMP_DRN : S_SUB_DRN;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            S_CMP_DRN: begin
               if (dv) begin
                  if (wa == LAST) begin
                     sel    <= an | ~b_nxt;
                     b      <= 1'b0;
                     wa     <= '0;
                     rd_ena <= 1'b1;
                     state  <= S_SUB;
                  end else begin
                     b  <= b_nxt;
                     wa <= wa + 1'b1;
                  end
               end
            end
            S_SUB_DRN: begin
               if (dv) begin
                  if (wa == LAST) begin
                     comp_end <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     b  <= b_nxt;
                     wa <= wa + 1'b1;
                  end
               end
            end
            S_DONE: begin
               comp_end <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmp_iddmm_finalsub.sv
// tb_mmp_iddmm_finalsub: vector table + write scoreboard for the final subtraction.
// Honours MMP_FINALSUB_FAST_AN_EN for expected latency.
module tb_mmp_iddmm_finalsub;

   localparam int K      = 128;
   localparam int N      = 32;
   localparam int AW     = 5;
   localparam int RD_LAT = 1;
   localparam int W      = K * N;
`ifdef MMP_FINALSUB_FAST_AN_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          comp_req = 1'b0;
   logic          ref_an = 1'b0;
   logic          comp_end;
   logic          busy;
   logic          rd_ena;
   logic [AW-1:0] rd_addr;
   logic [K-1:0]  a_rdata = '0;
   logic [K-1:0]  m_rdata = '0;
   logic          res_wr_ena;
   logic [AW-1:0] res_wr_addr;
   logic [K-1:0]  res_wr_data;

   mmp_iddmm_finalsub #(.K(K), .N(N), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .comp_req(comp_req), .ref_an(ref_an),
      .comp_end(comp_end), .busy(busy), .rd_ena(rd_ena), .rd_addr(rd_addr),
      .a_rdata(a_rdata), .m_rdata(m_rdata), .res_wr_ena(res_wr_ena),
      .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] m;
      bit           an;
      logic [W-1:0] r;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [K-1:0]  data;
   } exp_t;

   logic [K-1:0] amem [N];
   logic [K-1:0] mmem [N];
   exp_t         exp_q[$];
   vec_t         tv[7];
   int           nchk = 0;
   int           nerr = 0;
   int           ecnt = 0;
   int           nwr  = 0;

   // Synchronous A/M RAM model, one cycle read latency.
   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      if (rd_ena) begin
         a_rdata <= amem[rd_addr];
         m_rdata <= mmem[rd_addr];
      end
   end

   task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every result write is popped and compared.
   always @(negedge clk) begin
      if (rst_n && res_wr_ena) begin
         exp_t e;
         nwr++;
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_write: addr %0d data %0h", res_wr_addr, res_wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", K'(res_wr_addr), K'(e.addr));
            chk("wr_data", res_wr_data, e.data);
         end
      end
   end

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] m, input logic [W-1:0] r);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         amem[k] = a[k*K +: K];
         mmem[k] = m[k*K +: K];
         e.addr  = AW'(k);
         e.data  = r[k*K +: K];
         exp_q.push_back(e);
      end
   endtask

   task automatic run(input vec_t v, input int hold);
      int lat;
      int got;
      int start;
      int w0;
      load(v.a, v.m, v.r);
      lat = (FAST && v.an) ? N + RD_LAT + 1 : 2*N + 2*RD_LAT + 1;
      w0  = nwr;
      @(negedge clk);
      ref_an   = v.an;
      comp_req = 1'b1;
      start    = ecnt;
      @(negedge clk);
      ref_an = ~v.an;
      chk("busy_start", K'(busy), K'(1));
      chk("rd_ena_start", K'(rd_ena), K'(1));
      chk("rd_addr_start", K'(rd_addr), K'(0));
      got = -1;
      for (int c = 1; c < 300; c++) begin
         if (comp_end) begin
            got = ecnt - start;
            break;
         end
         @(negedge clk);
      end
      chk("comp_end_cycle", K'(got), K'(lat));
      chk("busy_at_end", K'(busy), K'(1));
      if (hold == 0) comp_req = 1'b0;
      @(negedge clk);
      chk("comp_end_pulse", K'(comp_end), K'(0));
      chk("busy_clear", K'(busy), K'(0));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("no_restart_busy", K'(busy), K'(0));
         chk("no_restart_rd", K'(rd_ena), K'(0));
      end
      comp_req = 1'b0;
      chk("write_count", K'(nwr - w0), K'(N));
      chk("queue_empty", K'(exp_q.size()), K'(0));
   endtask

   initial begin
      logic [W-1:0] mm;
      logic [W-1:0] t;
      logic [W-1:0] ra;
      logic [W-1:0] rm;
      bit           found;
      int           stray;

      for (int k = 0; k < N; k++)
         mm[k*K +: K] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mm[W-1] = 1'b0;
      t = W'(1) << K;
      tv[0] = '{a: mm + W'(5), m: mm, an: 1'b0, r: W'(5)};
      tv[1] = '{a: mm - W'(1), m: mm, an: 1'b0, r: mm - W'(1)};
      tv[2] = '{a: mm, m: mm, an: 1'b0, r: '0};
      tv[3] = '{a: t, m: W'(1), an: 1'b1, r: t - W'(1)};
      rm = (W'({K{1'b1}}) << K) | W'(1);
      tv[4] = '{a: W'(5) << K, m: rm, an: 1'b0, r: W'(5) << K};
      for (int i = 5; i < 7; i++) begin
         for (int k = 0; k < N; k++) begin
            ra[k*K +: K] = {$urandom(), $urandom(), $urandom(), $urandom()};
            rm[k*K +: K] = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         tv[i].a  = ra;
         tv[i].m  = rm;
         tv[i].an = (i == 6);
         tv[i].r  = (tv[i].an || ra >= rm) ? ra - rm : ra;
      end

      repeat (2) @(negedge clk);
      chk("rst_comp_end", K'(comp_end), K'(0));
      chk("rst_busy", K'(busy), K'(0));
      chk("rst_rd_ena", K'(rd_ena), K'(0));
      chk("rst_rd_addr", K'(rd_addr), K'(0));
      chk("rst_wr_ena", K'(res_wr_ena), K'(0));
      chk("rst_wr_addr", K'(res_wr_addr), K'(0));
      chk("rst_wr_data", res_wr_data, K'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run(tv[i], 0);

      run(tv[0], 3);
      run(tv[2], 0);

      load(tv[1].a, tv[1].m, tv[1].r);
      @(negedge clk);
      ref_an   = 1'b0;
      comp_req = 1'b1;
      found    = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (res_wr_ena && res_wr_addr == AW'(10)) begin
            found = 1'b1;
            break;
         end
      end
      chk("reached_word10", K'(found), K'(1));
      #1;
      rst_n    = 1'b0;
      comp_req = 1'b0;
      #1;
      chk("arst_comp_end", K'(comp_end), K'(0));
      chk("arst_busy", K'(busy), K'(0));
      chk("arst_rd_ena", K'(rd_ena), K'(0));
      chk("arst_rd_addr", K'(rd_addr), K'(0));
      chk("arst_wr_ena", K'(res_wr_ena), K'(0));
      chk("arst_wr_addr", K'(res_wr_addr), K'(0));
      chk("arst_wr_data", res_wr_data, K'(0));
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (80) begin
         @(negedge clk);
         if (comp_end || res_wr_ena || busy) stray++;
      end
      chk("quiet_after_reset", K'(stray), K'(0));
      run(tv[3], 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
